// File: rtl/float_align_pipe.sv
// float_align_pipe: multi-lane operand-alignment front end for the float adder.
//
// Per lane, the two operands are ordered by effective exponent. The larger one goes
// first, and on a tie lhs stays the larger. The exponent difference is computed, and
// the smaller operand's extended mantissa is right-shifted by that difference. Bits
// shifted out are collected into a sticky LSB.
//
// The block has two register stages under a single valid/ready handshake. All lanes
// move together.
//   Stage 1: swap decision, operand ordering and exponent difference.
//   Stage 2: alignment shift with sticky.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   lhs, rhs              LANES packed floats {sign, exp, man}, lane i at [i*FW +: FW]
//   out_valid / out_ready output beat handshake
//   big_sign, big_exp     sign and effective exponent of the larger operand
//   big_man               {hidden, man, GUARD_BITS zeros} of the larger operand
//   small_sign            sign of the smaller operand
//   small_man             aligned mantissa of the smaller operand, LSB is sticky
//   exp_diff              effective exponent difference, unsaturated
//   swapped               1 when rhs was selected as the larger operand

module float_align_pipe #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MAN_WIDTH  = 7,
    parameter int unsigned LANES      = 4,
    parameter int unsigned GUARD_BITS = 3,
    localparam int unsigned FW = EXP_WIDTH + MAN_WIDTH + 1,
    localparam int unsigned XW = MAN_WIDTH + 1 + GUARD_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*FW-1:0]        lhs,
    input  logic [LANES*FW-1:0]        rhs,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           big_sign,
    output logic [LANES*EXP_WIDTH-1:0] big_exp,
    output logic [LANES*XW-1:0]        big_man,
    output logic [LANES-1:0]           small_sign,
    output logic [LANES*XW-1:0]        small_man,
    output logic [LANES*EXP_WIDTH-1:0] exp_diff,
    output logic [LANES-1:0]           swapped
);

    // Stage 1 holds the ordered operands; mantissas include the hidden bit.
    typedef struct packed {
        logic                 big_sign;
        logic [EXP_WIDTH-1:0] big_exp;
        logic [MAN_WIDTH:0]   big_m;
        logic                 small_sign;
        logic [MAN_WIDTH:0]   small_m;
        logic [EXP_WIDTH-1:0] diff;
        logic                 swapped;
    } s1_t;

    typedef struct packed {
        logic                 big_sign;
        logic [EXP_WIDTH-1:0] big_exp;
        logic [XW-1:0]        big_man;
        logic                 small_sign;
        logic [XW-1:0]        small_man;
        logic [EXP_WIDTH-1:0] diff;
        logic                 swapped;
    } s2_t;

    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv, in_fire;

    s1_t s1_d [LANES];
    s1_t s1_q [LANES];
    s2_t s2_d [LANES];
    s2_t s2_q [LANES];

    // A stage may take new data when it is empty or its contents move on this edge.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    assign out_valid = s2_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [FW-1:0]        a, b;
        logic                 a_hid, b_hid;
        logic [EXP_WIDTH-1:0] a_exp, b_exp;
        logic                 swap;
        s1_t                  lane_s1;

        assign a = lhs[i*FW +: FW];
        assign b = rhs[i*FW +: FW];

        // Zero exponent field means denormal: effective exponent 1, no hidden bit.
        assign a_hid = |a[FW-2 -: EXP_WIDTH];
        assign b_hid = |b[FW-2 -: EXP_WIDTH];
        assign a_exp = a_hid ? a[FW-2 -: EXP_WIDTH] : EXP_WIDTH'(1);
        assign b_exp = b_hid ? b[FW-2 -: EXP_WIDTH] : EXP_WIDTH'(1);

        // Strict compare so that equal exponents keep lhs as the larger operand.
        assign swap = b_exp > a_exp;

        always_comb begin
            lane_s1            = '0;
            lane_s1.swapped    = swap;
            if (swap) begin
                lane_s1.big_sign   = b[FW-1];
                lane_s1.big_exp    = b_exp;
                lane_s1.big_m      = {b_hid, b[MAN_WIDTH-1:0]};
                lane_s1.small_sign = a[FW-1];
                lane_s1.small_m    = {a_hid, a[MAN_WIDTH-1:0]};
                lane_s1.diff       = b_exp - a_exp;
            end else begin
                lane_s1.big_sign   = a[FW-1];
                lane_s1.big_exp    = a_exp;
                lane_s1.big_m      = {a_hid, a[MAN_WIDTH-1:0]};
                lane_s1.small_sign = b[FW-1];
                lane_s1.small_m    = {b_hid, b[MAN_WIDTH-1:0]};
                lane_s1.diff       = a_exp - b_exp;
            end
        end

        assign s1_d[i] = lane_s1;

        // Stage 2 alignment shift.
        logic [XW-1:0] ext, shifted, lost_mask;
        logic          far;
        s2_t           lane_s2;

        assign ext       = {s1_q[i].small_m, {GUARD_BITS{1'b0}}};
        // At or beyond XW every bit is shifted out, so only the sticky bit survives.
        assign far       = 32'(s1_q[i].diff) >= XW;
        assign shifted   = ext >> s1_q[i].diff;
        assign lost_mask = ~({XW{1'b1}} << s1_q[i].diff);

        always_comb begin
            lane_s2            = '0;
            lane_s2.big_sign   = s1_q[i].big_sign;
            lane_s2.big_exp    = s1_q[i].big_exp;
            lane_s2.big_man    = {s1_q[i].big_m, {GUARD_BITS{1'b0}}};
            lane_s2.small_sign = s1_q[i].small_sign;
            lane_s2.diff       = s1_q[i].diff;
            lane_s2.swapped    = s1_q[i].swapped;
            if (far) begin
                lane_s2.small_man = {{(XW-1){1'b0}}, |ext};
            end else begin
                lane_s2.small_man = shifted | {{(XW-1){1'b0}}, |(ext & lost_mask)};
            end
        end

        assign s2_d[i] = lane_s2;

        assign big_sign[i]                       = s2_q[i].big_sign;
        assign big_exp[i*EXP_WIDTH +: EXP_WIDTH] = s2_q[i].big_exp;
        assign big_man[i*XW +: XW]               = s2_q[i].big_man;
        assign small_sign[i]                     = s2_q[i].small_sign;
        assign small_man[i*XW +: XW]             = s2_q[i].small_man;
        assign exp_diff[i*EXP_WIDTH +: EXP_WIDTH] = s2_q[i].diff;
        assign swapped[i]                        = s2_q[i].swapped;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_q[i] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (in_fire) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_q[i] <= s1_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s2_q[i] <= '0;
            end
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            // Output registers only change when a real beat moves in, so a stall holds them.
            if (s2_adv && s1_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    s2_q[i] <= s2_d[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_float_align_pipe.sv
// Bench for float_align_pipe: table-driven lane-0 vectors with randomized other
// lanes, scoreboard queue checked by a negedge monitor, and hand-written reset and
// stall sequences.

module tb_float_align_pipe;

    localparam int unsigned E     = 8;
    localparam int unsigned M     = 7;
    localparam int unsigned L     = 4;
    localparam int unsigned G     = 3;
    localparam int unsigned FW    = E + M + 1;
    localparam int unsigned XW    = M + 1 + G;
    localparam int unsigned LW    = L * FW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [LW-1:0]   lhs, rhs;
    logic            out_valid;
    logic            out_ready;
    logic [L-1:0]    big_sign, small_sign, swapped;
    logic [L*E-1:0]  big_exp, exp_diff;
    logic [L*XW-1:0] big_man, small_man;

    float_align_pipe #(
        .EXP_WIDTH (E),
        .MAN_WIDTH (M),
        .LANES     (L),
        .GUARD_BITS(G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .big_sign  (big_sign),
        .big_exp   (big_exp),
        .big_man   (big_man),
        .small_sign(small_sign),
        .small_man (small_man),
        .exp_diff  (exp_diff),
        .swapped   (swapped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L-1:0]    bs;
        logic [L*E-1:0]  be;
        logic [L*XW-1:0] bm;
        logic [L-1:0]    ss;
        logic [L*XW-1:0] sm;
        logic [L*E-1:0]  ed;
        logic [L-1:0]    sw;
    } exp_t;

    // Lane-0 directed vector with hand-derived expectations.
    typedef struct {
        logic [FW-1:0] l;
        logic [FW-1:0] r;
        logic          sw;
        logic          bs;
        logic          ss;
        logic [E-1:0]  be;
        logic [XW-1:0] bm;
        logic [XW-1:0] sm;
        logic [E-1:0]  ed;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: effective exponents, ordering, then bit-serial shift collecting sticky.
    function automatic exp_t model(input logic [LW-1:0] l, input logic [LW-1:0] r);
        exp_t          e;
        logic [FW-1:0] a, b, bg, sml;
        int            ea, eb, ebg, esm, d;
        int unsigned   mb, ms, st;
        e = '0;
        for (int i = 0; i < int'(L); i++) begin
            a  = l[i*FW +: FW];
            b  = r[i*FW +: FW];
            ea = int'(a[FW-2:M]);
            eb = int'(b[FW-2:M]);
            if (ea == 0) ea = 1;
            if (eb == 0) eb = 1;
            if (eb > ea) begin
                bg = b; sml = a; ebg = eb; esm = ea; e.sw[i] = 1'b1;
            end else begin
                bg = a; sml = b; ebg = ea; esm = eb; e.sw[i] = 1'b0;
            end
            d  = ebg - esm;
            mb = ((bg[FW-2:M] != 0) ? (32'd1 << M) : 32'd0) + 32'(bg[M-1:0]);
            ms = ((sml[FW-2:M] != 0) ? (32'd1 << M) : 32'd0) + 32'(sml[M-1:0]);
            mb = mb << G;
            ms = ms << G;
            st = 0;
            for (int k = 0; k < d; k++) begin
                st = st | (ms & 32'd1);
                ms = ms >> 1;
            end
            e.bs[i]           = bg[FW-1];
            e.ss[i]           = sml[FW-1];
            e.be[i*E +: E]    = E'(ebg);
            e.ed[i*E +: E]    = E'(d);
            e.bm[i*XW +: XW]  = XW'(mb);
            e.sm[i*XW +: XW]  = XW'(ms | st);
        end
        return e;
    endfunction

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".big_sign"},   64'(big_sign),   64'(e.bs));
        chk({tag, ".big_exp"},    64'(big_exp),    64'(e.be));
        chk({tag, ".big_man"},    64'(big_man),    64'(e.bm));
        chk({tag, ".small_sign"}, 64'(small_sign), 64'(e.ss));
        chk({tag, ".small_man"},  64'(small_man),  64'(e.sm));
        chk({tag, ".exp_diff"},   64'(exp_diff),   64'(e.ed));
        chk({tag, ".swapped"},    64'(swapped),    64'(e.sw));
    endtask

    // Scoreboard monitor: a transfer happens at the next posedge when both are high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got out_valid 1 expected no beat");
            end else begin
                chk_out("beat", exp_q.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Present a beat, wait (bounded) for in_ready, record the expectation on acceptance.
    task automatic send(input logic [LW-1:0] l, input logic [LW-1:0] r, input exp_t e);
        int n = 0;
        lhs = l;
        rhs = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_word();
        logic [LW-1:0] w;
        for (int i = 0; i < int'(L); i++) w[i*FW +: FW] = FW'($urandom);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        vec_t          tab[8];
        logic [LW-1:0] l, r;
        exp_t          e;

        tab[0] = '{16'h3F80, 16'h4000, 1'b1, 1'b0, 1'b0, 8'h80, 11'h400, 11'h200, 8'd1};
        tab[1] = '{16'hBFC0, 16'h3F80, 1'b0, 1'b1, 1'b0, 8'h7F, 11'h600, 11'h400, 8'd0};
        tab[2] = '{16'h3F80, 16'h3580, 1'b0, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h001, 8'd20};
        tab[3] = '{16'h0080, 16'h0001, 1'b0, 1'b0, 1'b0, 8'h01, 11'h400, 11'h008, 8'd0};
        tab[4] = '{16'h3F80, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h000, 8'd126};
        tab[5] = '{16'h3F80, 16'h3B20, 1'b0, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h003, 8'd9};
        tab[6] = '{16'h3A00, 16'hBF80, 1'b1, 1'b1, 1'b0, 8'h7F, 11'h400, 11'h001, 8'd11};
        tab[7] = '{16'h7F80, 16'h7F80, 1'b0, 1'b0, 1'b0, 8'hFF, 11'h400, 11'h400, 8'd0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        lhs = '0;
        rhs = '0;
        #12;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.big_man",   64'(big_man),   64'd0);
        chk("reset.small_man", 64'(small_man), 64'd0);
        chk("reset.exp_diff",  64'(exp_diff),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors on lane 0, random operands on the other lanes.
        foreach (tab[v]) begin
            l = rand_word();
            r = rand_word();
            l[FW-1:0] = tab[v].l;
            r[FW-1:0] = tab[v].r;
            e = model(l, r);
            e.sw[0]       = tab[v].sw;
            e.bs[0]       = tab[v].bs;
            e.ss[0]       = tab[v].ss;
            e.be[E-1:0]   = tab[v].be;
            e.bm[XW-1:0]  = tab[v].bm;
            e.sm[XW-1:0]  = tab[v].sm;
            e.ed[E-1:0]   = tab[v].ed;
            send(l, r, e);
            @(negedge clk);
            chk("latency.cycle1", 64'(out_valid), 64'd0);
            @(negedge clk);
            chk("latency.cycle2", 64'(out_valid), 64'd1);
            drain();
        end

        // Stall: two beats fill the pipe, in_ready drops, outputs hold, then release.
        out_ready = 1'b0;
        pop_cyc.delete();
        for (int b = 0; b < 2; b++) begin
            l = rand_word();
            r = rand_word();
            send(l, r, model(l, r));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall.in_ready",  64'(in_ready),  64'd0);
            chk("stall.out_valid", 64'(out_valid), 64'd1);
            chk_out("stall.hold", exp_q[0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            l = rand_word();
            r = rand_word();
            send(l, r, model(l, r));
        end
        drain();
        chk("stall.beats_out", 64'(pop_cyc.size()), 64'd4);
        for (int k = 1; k < pop_cyc.size(); k++) begin
            chk("stall.one_per_cycle", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd1);
        end

        // Mid-stream reset with two beats in flight.
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            l = rand_word();
            r = rand_word();
            send(l, r, model(l, r));
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midreset.out_valid", 64'(out_valid), 64'd0);
        chk("midreset.big_man",   64'(big_man),   64'd0);
        chk("midreset.small_man", 64'(small_man), 64'd0);
        chk("midreset.swapped",   64'(swapped),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midreset.no_stale", 64'(out_valid), 64'd0);
        end

        // Pipeline still works after the reset.
        @(posedge clk);
        #1;
        l = rand_word();
        r = rand_word();
        send(l, r, model(l, r));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_align_pipe.md
Name: float_align_pipe

Overview:
- Multi-lane, pipelined operand-alignment front end for the float adder datapath.
- Per lane:
  - orders two floats by exponent, larger exponent first; ties keep lhs as larger.
  - computes the exponent difference.
  - right-shifts the smaller operand's extended mantissa by that difference, with guard and sticky bits.
- Sits between the operand fetch and the mantissa add/normalise stages.
- Two register stages under a valid/ready handshake.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MAN_WIDTH, 7, stored mantissa field width.
- LANES, 4, number of independent lanes sharing one handshake.
- GUARD_BITS, 3, extra LSBs appended below the mantissa; the lowest one is sticky. Must be >= 2.

Derived values:
- FW = EXP_WIDTH+MAN_WIDTH+1 (float word width).
- XW = MAN_WIDTH+1+GUARD_BITS (extended mantissa width).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- lhs  in  LANES*FW  lane i at [i*FW +: FW].
- rhs  in  LANES*FW  lane i at [i*FW +: FW].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat.
- big_sign  out  LANES  sign of the larger-exponent operand.
- big_exp  out  LANES*EXP_WIDTH  effective exponent of the larger operand.
- big_man  out  LANES*XW  {hidden, mantissa, GUARD_BITS zeros} of the larger operand.
- small_sign  out  LANES  sign of the smaller operand.
- small_man  out  LANES*XW  aligned mantissa of the smaller operand; LSB is sticky.
- exp_diff  out  LANES*EXP_WIDTH  effective exponent difference, unsaturated.
- swapped  out  LANES  1 when rhs was selected as the larger operand.

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, internal stage valids=0, all data registers and outputs 0. in_ready=1 once rst_n is high.
- Reset asserted mid-operation discards all in-flight beats immediately. No output is produced for them.
- Effective exponent and hidden bit:
  - field=0: effective exponent 1, hidden=0 (denormal).
  - field!=0: effective exponent = field, hidden=1.
  - Inf/NaN receive no special handling: exponent all-ones is ordinary, hidden=1.
- Stage 1, registered on an accepted beat:
  - swap decision: rhs is larger iff rhs_eff_exp > lhs_eff_exp (strict). Equal exponents → swapped=0.
  - captures both operands ordered (big, small), exp_diff = big_eff - small_eff, and swapped.
- Stage 2:
  - small extended mantissa = {hidden, man, GUARD_BITS'b0}.
  - shifted right by min(exp_diff, XW).
  - sticky: OR of all shifted-out bits, ORed into the result LSB.
  - exp_diff >= XW and mantissa nonzero → small_man = 1 (only sticky). Mantissa all zero → small_man = 0.
  - big fields registered unchanged; exp_diff output is the unsaturated value.
- Latency: exactly 2 cycles from the accepting edge to out_valid with no stall. Throughput 1 beat/cycle.
- Handshake:
  - transfer on valid&&ready at the rising edge.
  - stage k advances when its successor is empty or advancing.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational).
  - out_valid && !out_ready holds all outputs stable.
  - No beat is dropped or duplicated.
- in_valid=0 inserts a bubble; the pipeline drains normally.
- Simultaneous in accept and out accept with a full pipeline shifts all stages in one edge.
- All lanes move together; there is no per-lane valid.

Test Plan:
- Reset with rst_n=0 mid-stream holding 2 beats → out_valid=0 at once, outputs 0; after release in_ready=1 and no stale beat appears.
- Lane0 lhs=0x3F80 (1.0), rhs=0x4000 (2.0), bf16 defaults, one beat, out_ready=1 → after 2 cycles:
  - swapped=1, big_exp=0x80, big_man=0x400.
  - small_man=0x200, exp_diff=1, both signs 0.
- lhs=0xBFC0 (-1.5), rhs=0x3F80 (1.0), equal exponents → swapped=0, big_sign=1, big_man=0x600, small_man=0x400, exp_diff=0.
- lhs=0x3F80, rhs=0x3580 (2^-20) → exp_diff=20, small_man=0x001 (sticky only).
- Denormals: lhs=0x0080, rhs=0x0001 → big_exp=1, exp_diff=0, swapped=0, small_man=0x008.
- Back-to-back beats with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepted beats.
  - outputs stay stable while stalled.
  - on release, beats emerge in order, one per cycle, with no loss.
  - all 4 lanes carry distinct operands, each checked against a reference model.
